shake_absorb_ctrl: RTL and testbench

SHAKE_ABSORB_CTRL -- requirements
Module: shake_absorb_ctrl

---
 rtl/shake_absorb_ctrl_pkg.sv | 23 ++
 rtl/shake_absorb_ctrl_size_counter.sv | 30 +++
 rtl/shake_absorb_ctrl.sv | 172 +++++++++++++++++
 tb/tb_shake_absorb_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shake_absorb_ctrl_pkg.sv
// Shared SHAKE absorb definitions: controller states, rate sizes and padding bytes.
package shake_absorb_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        PERM_WAIT,
        FINAL_WAIT
    } state_t;

    localparam int RATE128_WORDS = 21;
    localparam int RATE256_WORDS = 17;

    localparam logic [7:0] PAD_DOMAIN = 8'h1F;
    localparam logic [7:0] PAD_LAST   = 8'h80;

    // Index of the last lane in the rate portion for the selected variant.
    function automatic logic [4:0] last_lane(input logic mode);
        return mode ? 5'(RATE256_WORDS - 1) : 5'(RATE128_WORDS - 1);
    endfunction

endpackage

// File: rtl/shake_absorb_ctrl_size_counter.sv
// Remaining-size down-counter: loads a length, subtracts a step per accepted word (saturating at 0).
// Flags are combinational from the current count; count updates one cycle after en_write/en_count.
module shake_absorb_ctrl_size_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en_write,
    input  logic [WIDTH-1:0] step_size,
    input  logic             en_count,
    output logic [WIDTH-1:0] count,
    output logic             counter_end,
    output logic             last_word
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '1;
        end else if (en_write) begin
            count <= data_in;
        end else if (en_count) begin
            count <= (count > step_size) ? count - step_size : '0;
        end
    end

    assign counter_end = (count == '0);
    assign last_word   = (count != '0) && (count <= step_size);

endmodule

// File: rtl/shake_absorb_ctrl.sv
// SHAKE128/256 absorb sequencer: streams message words, applies 0x1F..0x80 padding, requests permutations.
// word_we/word_out are combinational with the accepted word; in_ready drops outside ABSORB or once the message is consumed.
module shake_absorb_ctrl
    import shake_absorb_ctrl_pkg::*;
#(
    parameter int W         = 64,
    parameter int LEN_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [LEN_WIDTH-1:0] msg_len,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W-1:0]         word_out,
    output logic                 word_we,
    output logic [4:0]           word_idx,
    output logic                 perm_start,
    input  logic                 perm_done,
    output logic                 busy,
    output logic                 absorb_done
);

    localparam int NBYTES = W / 8;
    localparam logic [LEN_WIDTH-1:0] STEP = LEN_WIDTH'(W);

    state_t               state, state_nxt;
    logic                 mode_q;
    logic [4:0]           idx_nxt;
    logic                 dom_owed, dom_owed_nxt;
    logic                 perm_start_nxt, absorb_done_nxt;
    logic [LEN_WIDTH-1:0] remaining;
    logic [LEN_WIDTH-1:0] k_bytes;
    logic                 counter_end, last_word;
    logic                 load, transfer, partial, at_last;

    assign load     = (state == IDLE) && start;
    assign in_ready = (state == ABSORB) && !counter_end;
    assign transfer = in_valid && in_ready;
    assign partial  = remaining < STEP;
    assign k_bytes  = remaining >> 3;
    assign at_last  = (word_idx == last_lane(mode_q));
    assign busy     = (state != IDLE);

    shake_absorb_ctrl_size_counter #(
        .WIDTH(LEN_WIDTH)
    ) u_remaining (
        .clk        (clk),
        .rst        (rst),
        .data_in    (msg_len),
        .en_write   (load),
        .step_size  (STEP),
        .en_count   (transfer),
        .count      (remaining),
        .counter_end(counter_end),
        .last_word  (last_word)
    );

    always_comb begin
        word_out = '0;
        word_we  = 1'b0;
        if (transfer) begin
            word_we = 1'b1;
            if (!partial) begin
                word_out = in_data;
            end else begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (LEN_WIDTH'(b) < k_bytes) begin
                        word_out[8*b +: 8] = in_data[8*b +: 8];
                    end else if (LEN_WIDTH'(b) == k_bytes) begin
                        word_out[8*b +: 8] = PAD_DOMAIN;
                    end
                end
                if (at_last) begin
                    word_out[W-1 -: 8] = word_out[W-1 -: 8] | PAD_LAST;
                end
            end
        end else if (state == PAD) begin
            word_we = 1'b1;
            if (dom_owed) begin
                word_out[7:0] = PAD_DOMAIN;
            end
            if (at_last) begin
                word_out[W-1 -: 8] = word_out[W-1 -: 8] | PAD_LAST;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        idx_nxt         = word_idx;
        dom_owed_nxt    = dom_owed;
        perm_start_nxt  = 1'b0;
        absorb_done_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = ABSORB;
                    idx_nxt      = '0;
                    dom_owed_nxt = 1'b1;
                end
            end
            ABSORB: begin
                if (counter_end) begin
                    state_nxt    = PAD;
                    dom_owed_nxt = 1'b1;
                end else if (transfer) begin
                    if (at_last) begin
                        // A partial word in the last lane already carries 0x1F|0x80: block is final.
                        idx_nxt        = '0;
                        perm_start_nxt = 1'b1;
                        state_nxt      = partial ? FINAL_WAIT : PERM_WAIT;
                    end else begin
                        idx_nxt = word_idx + 5'd1;
                        if (partial) begin
                            state_nxt    = PAD;
                            dom_owed_nxt = 1'b0;
                        end else if (last_word) begin
                            state_nxt    = PAD;
                            dom_owed_nxt = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                dom_owed_nxt = 1'b0;
                if (at_last) begin
                    idx_nxt        = '0;
                    perm_start_nxt = 1'b1;
                    state_nxt      = FINAL_WAIT;
                end else begin
                    idx_nxt = word_idx + 5'd1;
                end
            end
            PERM_WAIT: begin
                if (perm_done) begin
                    state_nxt = counter_end ? PAD : ABSORB;
                end
            end
            FINAL_WAIT: begin
                if (perm_done) begin
                    state_nxt       = IDLE;
                    absorb_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            word_idx    <= '0;
            mode_q      <= 1'b0;
            dom_owed    <= 1'b0;
            perm_start  <= 1'b0;
            absorb_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            word_idx    <= idx_nxt;
            dom_owed    <= dom_owed_nxt;
            perm_start  <= perm_start_nxt;
            absorb_done <= absorb_done_nxt;
            if (load) begin
                mode_q <= mode;
            end
        end
    end

endmodule

// File: tb/tb_shake_absorb_ctrl.sv
// Bench for shake_absorb_ctrl: byte-level sponge padding model feeds a scoreboard checked by a monitor.
module tb_shake_absorb_ctrl;

    localparam int W  = 64;
    localparam int LW = 32;

    logic          clk, rst, start, mode;
    logic [LW-1:0] msg_len;
    logic [W-1:0]  in_data;
    logic          in_valid, in_ready;
    logic [W-1:0]  word_out;
    logic          word_we;
    logic [4:0]    word_idx;
    logic          perm_start, perm_done, busy, absorb_done;

    typedef struct {
        int          kind;   // 0 = write, 1 = perm_start, 2 = absorb_done
        logic [4:0]  idx;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    shake_absorb_ctrl #(.W(W), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .msg_len    (msg_len),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .word_out   (word_out),
        .word_we    (word_we),
        .word_idx   (word_idx),
        .perm_start (perm_start),
        .perm_done  (perm_done),
        .busy       (busy),
        .absorb_done(absorb_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: standard SHAKE pad10*1 on a byte string, then split into rate-sized blocks of LE words.
    task automatic build_expect(input logic m, input int len_bits, input logic [63:0] words[$]);
        logic [7:0] b[$];
        int rb;
        rb = m ? 136 : 168;
        for (int i = 0; i < len_bits / 8; i++) b.push_back(words[i/8][8*(i%8) +: 8]);
        b.push_back(8'h1F);
        while (b.size() % rb != 0) b.push_back(8'h00);
        b[b.size()-1] = b[b.size()-1] | 8'h80;
        for (int blk = 0; blk < b.size() / rb; blk++) begin
            for (int w = 0; w < rb / 8; w++) begin
                logic [63:0] d;
                d = '0;
                for (int j = 0; j < 8; j++) d[8*j +: 8] = b[blk*rb + w*8 + j];
                exp_q.push_back('{0, 5'(w), d});
            end
            exp_q.push_back('{1, 5'd0, 64'd0});
        end
        exp_q.push_back('{2, 5'd0, 64'd0});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},    64'(in_ready),    64'd0);
        check({tag, "_word_we"},     64'(word_we),     64'd0);
        check({tag, "_perm_start"},  64'(perm_start),  64'd0);
        check({tag, "_absorb_done"}, 64'(absorb_done), 64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_word_out"},    word_out,         64'd0);
    endtask

    task automatic run_msg(input logic m, input int len, input bit use_fill, input logic [63:0] fill,
                           input bit toggle, input int abort_after);
        logic [63:0] words[$];
        int nw, ptr, d0, cyc;
        nw  = (len + 63) / 64;
        ptr = 0;
        cyc = 0;
        for (int i = 0; i < nw; i++) words.push_back(use_fill ? fill : {$urandom, $urandom});
        build_expect(m, len, words);
        @(posedge clk); #1;
        start   = 1'b1;
        mode    = m;
        msg_len = LW'(len);
        d0      = done_cnt;
        @(posedge clk); #1;
        start   = 1'b0;
        mode    = 1'($urandom_range(0, 1));
        msg_len = $urandom;
        while (done_cnt == d0 && cyc < 3000) begin
            if (ptr < nw) begin
                in_valid = toggle ? !in_valid : ($urandom_range(0, 3) != 0);
                in_data  = words[ptr];
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom, $urandom};
            end
            @(negedge clk);
            if (in_valid && in_ready) ptr++;
            @(posedge clk); #1;
            cyc++;
            if (abort_after != 0 && ptr == abort_after) begin
                in_valid = 1'b0;
                #2 rst = 1'b1;
                #1 check_all_zero("midrst");
                exp_q.delete();
                repeat (4) @(posedge clk);
                #1 rst = 1'b0;
                repeat (8) @(posedge clk);
                return;
            end
        end
        in_valid = 1'b0;
        check("absorb_done_count", 64'(done_cnt - d0), 64'd1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("words_consumed", 64'(ptr), 64'(nw));
    endtask

    // Permutation stub: completes each request after a random delay; stray pulses during ABSORB.
    initial begin
        int pend;
        pend      = 0;
        perm_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            perm_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (perm_start) begin
                pend = $urandom_range(1, 4);
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) perm_done = 1'b1;
            end else if (in_ready && $urandom_range(0, 5) == 0) begin
                perm_done = 1'b1;
            end
        end
    end

    // Monitor: every output event pops the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (word_we) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(word_idx), 64'h7f);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_is_write", 64'(e.kind), 64'd0);
                        check("word_idx", 64'(word_idx), 64'(e.idx));
                        check("word_out", word_out, e.data);
                    end
                end
                if (perm_start) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_perm_start", 64'(perm_start), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_is_perm_start", 64'(e.kind), 64'd1);
                        check("in_ready_during_perm", 64'(in_ready), 64'd0);
                    end
                end
                if (absorb_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_absorb_done", 64'(absorb_done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_is_absorb_done", 64'(e.kind), 64'd2);
                        check("busy_after_done", 64'(busy), 64'd0);
                    end
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        msg_len  = '0;
        in_data  = '0;
        in_valid = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_msg(1'b0, 0,    1'b0, 64'd0,                 1'b0, 0);
        run_msg(1'b1, 64,   1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
        run_msg(1'b0, 1344, 1'b0, 64'd0,                 1'b0, 0);
        run_msg(1'b0, 1336, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_msg(1'b1, 200,  1'b0, 64'd0,                 1'b1, 0);
        run_msg(1'b0, 1000, 1'b0, 64'd0,                 1'b0, 3);
        run_msg(1'b0, 0,    1'b0, 64'd0,                 1'b0, 0);
        run_msg(1'b1, 1088, 1'b0, 64'd0,                 1'b0, 0);
        for (int n = 0; n < 12; n++) begin
            run_msg(1'($urandom_range(0, 1)), 8 * $urandom_range(0, 420), 1'b0, 64'd0,
                    1'($urandom_range(0, 1)), 0);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
